bundle_fetch_queue: RTL and testbench

//   Fetch front end for the N-wide TTA core. Owns the PC and issues N-instruction bundle reads to

---
 rtl/bundle_fetch_queue.sv | 135 +++++++++++++
 tb/tb_bundle_fetch_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bundle_fetch_queue.sv
// ============================================================================
// Module      : bundle_fetch_queue
// Description : TTA fetch front end. It owns the PC, issues N-wide bundle reads,
//               and buffers PC-tagged bundles in a DEPTH-entry FIFO for decode.
//               Optional macro FETCH_PERF_CNT_EN adds a stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bundle_fetch_queue #(
  parameter int N     = 2,
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         imem_req,
  output logic [PC_W-1:0]              imem_addr,
  input  logic [32*N-1:0]              imem_rdata,
  input  logic                         redirect_valid,
  input  logic [PC_W-1:0]              redirect_pc,
  output logic                         bundle_valid,
  input  logic                         bundle_ready,
  output logic [32*N-1:0]              bundle_instr,
  output logic [PC_W-1:0]              bundle_pc,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_stall_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4*N);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [32*N-1:0]   instr_mem_q [DEPTH];
  logic [PC_W-1:0]   pc_mem_q    [DEPTH];

  logic              credit_ok;
  logic              push;
  logic              pop;

  // Outstanding request reserves a slot so a returning bundle always fits.
  assign credit_ok = ({1'b0, count_q} + (CNT_W+1)'(inflight_q)) < (CNT_W+1)'(DEPTH);
  assign imem_req  = !rst && !redirect_valid && credit_ok;
  assign imem_addr = pc_q;

  assign bundle_valid = (count_q != '0);
  assign bundle_instr = bundle_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign bundle_pc    = bundle_valid ? pc_mem_q[rd_ptr_q]    : '0;
  assign fifo_count   = count_q;

  assign push = inflight_q && !redirect_valid;
  assign pop  = bundle_valid && bundle_ready;

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = imem_req;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc & ALIGN_MASK;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (imem_req) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + PC_STEP;
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: reads are masked by count_q when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;
  logic        stall;

  assign stall = (bundle_valid && !bundle_ready) || !credit_ok;

  always_comb begin
    perf_d = perf_q;
    if (stall && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_stall_cycles = perf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bundle_fetch_queue.sv
// ============================================================================
// Module      : tb_bundle_fetch_queue
// Description : Directed self-checking bench for bundle_fetch_queue (N=2, DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bundle_fetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [63:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        bundle_valid;
  logic        bundle_ready;
  logic [63:0] bundle_instr;
  logic [31:0] bundle_pc;
  logic [2:0]  fifo_count;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
`endif

  int chk_cnt = 0;
  int err_cnt = 0;

  bundle_fetch_queue #(.N(2), .DEPTH(4), .PC_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bundle_valid   (bundle_valid),
    .bundle_ready   (bundle_ready),
    .bundle_instr   (bundle_instr),
    .bundle_pc      (bundle_pc),
    .fifo_count     (fifo_count)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] bundle_of(input logic [31:0] a);
    logic [31:0] s0, s1;
    s0 = a ^ 32'h5A5A_0000;
    s1 = (a + 32'd4) ^ 32'h5A5A_0000;
    return {s1, s0};
  endfunction

  // Instruction memory with one-cycle read latency.
  initial imem_rdata = '0;
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= bundle_of(imem_addr);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Leaves the bench in cycle 0 after reset release, inputs settled.
  task automatic do_reset(input logic rdy);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    bundle_ready   = rdy;
    tick();
    check("rst_req",   64'(imem_req),     64'd0);
    check("rst_valid", 64'(bundle_valid), 64'd0);
    check("rst_count", 64'(fifo_count),   64'd0);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int nreq;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    bundle_ready   = 1'b0;
    tick();
    check("reset_addr",  64'(imem_addr),  64'd0);
    check("reset_pc",    64'(bundle_pc),  64'd0);
    check("reset_instr", bundle_instr,    64'd0);

    // 1: streaming with no backpressure
    do_reset(1'b1);
    check("t1_req0",  64'(imem_req),  64'd1);
    check("t1_addr0", 64'(imem_addr), 64'd0);
    tick(); #1;
    check("t1_addr1",  64'(imem_addr),    64'd8);
    check("t1_valid1", 64'(bundle_valid), 64'd0);
    tick(); #1;
    check("t1_valid2", 64'(bundle_valid), 64'd1);
    check("t1_pc2",    64'(bundle_pc),    64'd0);
    check("t1_instr2", bundle_instr,      bundle_of(32'd0));
    for (int k = 1; k <= 4; k++) begin
      tick(); #1;
      check("t1_pc",    64'(bundle_pc),  64'(32'(8*k)));
      check("t1_instr", bundle_instr,    bundle_of(32'(8*k)));
      check("t1_count", 64'(fifo_count), 64'd1);
    end

    // 2: backpressure fills the FIFO with exactly four requests
    do_reset(1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("t2_perf0", 64'(perf_stall_cycles), 64'd0);
`endif
    nreq = 0;
    for (int k = 0; k < 10; k++) begin
      if (imem_req) begin
        check("t2_addr", 64'(imem_addr), 64'(32'(8*nreq)));
        nreq++;
      end
      tick(); #1;
    end
    check("t2_nreq",  64'(nreq),       64'd4);
    check("t2_count", 64'(fifo_count), 64'd4);
    check("t2_req",   64'(imem_req),   64'd0);
`ifdef FETCH_PERF_CNT_EN
    check("t2_perf", 64'(perf_stall_cycles), 64'd8);
`endif
    bundle_ready = 1'b1; #1;
    for (int k = 0; k < 4; k++) begin
      check("t2_drain_pc",    64'(bundle_pc), 64'(32'(8*k)));
      check("t2_drain_instr", bundle_instr,   bundle_of(32'(8*k)));
      tick(); #1;
    end

    // 3: single pop from full, credit returns next cycle
    do_reset(1'b0);
    for (int k = 0; k < 8; k++) tick();
    #1;
    check("t3_full", 64'(fifo_count), 64'd4);
    bundle_ready = 1'b1; #1;
    check("t3_req_pop", 64'(imem_req),  64'd0);
    check("t3_head",    64'(bundle_pc), 64'd0);
    tick();
    bundle_ready = 1'b0; #1;
    check("t3_count3", 64'(fifo_count), 64'd3);
    check("t3_req",    64'(imem_req),   64'd1);
    check("t3_addr",   64'(imem_addr),  64'd32);
    check("t3_head2",  64'(bundle_pc),  64'd8);
    tick(); #1;
    check("t3_req_off", 64'(imem_req),   64'd0);
    tick(); #1;
    check("t3_count4",  64'(fifo_count), 64'd4);

    // 4: redirect with three queued and one in flight
    do_reset(1'b0);
    for (int k = 0; k < 4; k++) tick();
    #1;
    check("t4_count_pre", 64'(fifo_count), 64'd3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    check("t4_req_T", 64'(imem_req), 64'd0);
    tick();
    redirect_valid = 1'b0;
    bundle_ready   = 1'b1;
    #1;
    check("t4_count", 64'(fifo_count),   64'd0);
    check("t4_valid", 64'(bundle_valid), 64'd0);
    check("t4_req",   64'(imem_req),     64'd1);
    check("t4_addr",  64'(imem_addr),    64'h100);
    tick(); #1;
    check("t4_addr2",  64'(imem_addr),    64'h108);
    check("t4_valid2", 64'(bundle_valid), 64'd0);
    tick(); #1;
    check("t4_pc",    64'(bundle_pc), 64'h100);
    check("t4_instr", bundle_instr,   bundle_of(32'h100));

    // 5: PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    #1;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("t5_addr_top", 64'(imem_addr), 64'hFFFF_FFF8);
    tick(); #1;
    check("t5_addr_wrap", 64'(imem_addr), 64'd0);
    check("t5_req_wrap",  64'(imem_req),  64'd1);
    tick(); #1;
    check("t5_pc_top",    64'(bundle_pc), 64'hFFFF_FFF8);
    check("t5_instr_top", bundle_instr,   bundle_of(32'hFFFF_FFF8));
    tick(); #1;
    check("t5_pc_wrap",   64'(bundle_pc), 64'd0);

    // 6: asynchronous reset mid-operation
    do_reset(1'b0);
    for (int k = 0; k < 3; k++) tick();
    #1;
    check("t6_count_pre", 64'(fifo_count), 64'd2);
    rst = 1'b1;
    #1;
    check("t6_valid", 64'(bundle_valid), 64'd0);
    check("t6_count", 64'(fifo_count),   64'd0);
    check("t6_req",   64'(imem_req),     64'd0);
    check("t6_pc",    64'(bundle_pc),    64'd0);
    check("t6_instr", bundle_instr,      64'd0);
    check("t6_addr",  64'(imem_addr),    64'd0);
    tick();
    rst          = 1'b0;
    bundle_ready = 1'b1;
    #1;
    check("t6_restart", 64'(imem_addr), 64'd0);
    tick(); #1;
    check("t6_stale_count", 64'(fifo_count),   64'd0);
    check("t6_stale_valid", 64'(bundle_valid), 64'd0);
    tick(); #1;
    check("t6_pc0",    64'(bundle_pc), 64'd0);
    check("t6_instr0", bundle_instr,   bundle_of(32'd0));

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule

`default_nettype wire
